// File: rtl/sindoku_btn_pulser.sv
// Button front end for the sindoku core: synchronize, debounce and arbitrate six
// raw pushbuttons into single-clock pulses, at most one pulse high per clock.
// Latency from first raw sample to pulse is DB_COUNT+3 clocks without contention.
module sindoku_btn_pulser #(
  parameter int DB_COUNT = 1000000,
  parameter int CNT_W    = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnR,
  input  logic       BtnL,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnC,
  input  logic       BtnCheck,
  output logic       R,
  output logic       L,
  output logic       U,
  output logic       D,
  output logic       C,
  output logic       CheckSolu,
  output logic [5:0] btn_level
);

  // Bit order everywhere: {Check, C, R, L, U, D}; a higher index means higher
  // arbitration priority, so the arbiter simply scans from the top down.
  localparam int NB = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WQ   = 2'd1,
    HELD = 2'd2,
    WREL = 2'd3
  } db_state_e;

  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;
  logic [NB-1:0] qualify;
  logic [NB-1:0] level;
  logic [NB-1:0] pend_q;
  logic [NB-1:0] pend_d;
  logic [NB-1:0] grant_d;
  logic [NB-1:0] pulse_q;
  logic          found;

  assign raw = {BtnCheck, BtnC, BtnR, BtnL, BtnU, BtnD};

  // Two-flop synchronizer for the asynchronous raw buttons; only s2 is used.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s2_next(s1_q);
    end
  end

  function automatic logic [NB-1:0] s2_next(input logic [NB-1:0] s1);
    return s1;
  endfunction

  for (genvar g = 0; g < NB; g++) begin : g_btn
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;

    // Debounce FSM: a press or release is accepted only after the synchronized
    // level has held steady long enough; a bounce restarts the wait.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (s2_q[g]) begin
              state_q <= WQ;
              cnt_q   <= '0;
            end
          end
          WQ: begin
            if (!s2_q[g]) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          HELD: begin
            if (!s2_q[g]) begin
              state_q <= WREL;
              cnt_q   <= '0;
            end
          end
          WREL: begin
            if (s2_q[g]) begin
              // Release glitch: back to held without raising a new press.
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    // The WQ->HELD edge is the moment a press becomes pending.
    assign qualify[g] = (state_q == WQ) && s2_q[g] && (cnt_q == CNT_LAST);
    assign level[g]   = (state_q == HELD) || (state_q == WREL);
  end

  // Fixed-priority grant over the registered pending bits; newly qualified
  // presses join the pending set and compete from the next clock on.
  always_comb begin
    grant_d = '0;
    found   = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (pend_q[i] && !found) begin
        grant_d[i] = 1'b1;
        found      = 1'b1;
      end
    end
    pend_d = (pend_q & ~grant_d) | qualify;
  end

  // Pending set and registered one-hot pulse outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_q  <= '0;
      pulse_q <= '0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= grant_d;
    end
  end

  assign {CheckSolu, C, R, L, U, D} = pulse_q;
  assign btn_level = level;

endmodule

// File: tb/tb_sindoku_btn_pulser.sv
module tb_sindoku_btn_pulser;
  localparam int DB = 4;
  localparam int CW = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] raw = '0;
  logic       R, L, U, D, C, CheckSolu;
  logic [5:0] btn_level;
  logic [5:0] dut_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  sindoku_btn_pulser #(.DB_COUNT(DB), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .BtnR(raw[3]), .BtnL(raw[2]), .BtnU(raw[1]), .BtnD(raw[0]),
    .BtnC(raw[4]), .BtnCheck(raw[5]),
    .R(R), .L(L), .U(U), .D(D), .C(C), .CheckSolu(CheckSolu),
    .btn_level(btn_level)
  );

  assign dut_pulse = {CheckSolu, C, R, L, U, D};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a button's debounced level flips once the synchronized
  // input has differed from it for DB+1 consecutive samples; each accepted
  // press queues a request, and requests are served highest-priority first.
  logic [5:0] m_s1, m_s2, m_lvl, m_pend, m_out;
  int         m_run [6];

  always @(posedge Clk or posedge Reset) begin
    logic [5:0] acc;
    logic [5:0] gnt;
    if (Reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_out = '0;
      for (int b = 0; b < 6; b++) m_run[b] = 0;
    end else begin
      acc = '0;
      gnt = '0;
      for (int b = 5; b >= 0; b--)
        if (m_pend[b] && gnt == 6'd0) gnt[b] = 1'b1;
      for (int b = 0; b < 6; b++) begin
        if (m_s2[b] != m_lvl[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == DB + 1) begin
            m_lvl[b] = ~m_lvl[b];
            m_run[b] = 0;
            if (m_lvl[b]) acc[b] = 1'b1;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_out  = gnt;
      m_pend = (m_pend & ~gnt) | acc;
      m_s2   = m_s1;
      m_s1   = raw;
    end
  end

  // Every-cycle comparison of DUT against the model.
  always @(negedge Clk) begin
    chk("pulses_vs_model", int'(dut_pulse), int'(m_out));
    chk("level_vs_model", int'(btn_level), int'(m_lvl));
    chk("pulse_onehot0", int'($onehot0(dut_pulse)), 1);
  end

  // Directed-scenario recording (edge indices relative to scenario start).
  int pc [6], pf [6], pl [6], lf [6], mf [6];

  function automatic logic [5:0] raw_at(input int sc, input int k);
    logic [5:0] v;
    v = '0;
    case (sc)
      1: if (k < 20) v = 6'b001000;
      2: if (k < 2 || k >= 3) v = 6'b010000;
      3: if (k < 15) v = 6'b000110;
      4: if (k < 20 || k == 22 || (k >= 33 && k < 50)) v = 6'b001000;
      5: v = 6'b000001;
      6: if (k < 15) v = 6'b110000;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic run_scen(input int sc, input int n);
    for (int b = 0; b < 6; b++) begin
      pc[b] = 0; pf[b] = -1; pl[b] = -1; lf[b] = -1; mf[b] = -1;
    end
    for (int k = 0; k < n; k++) begin
      raw = raw_at(sc, k);
      @(posedge Clk);
      #1;
      for (int b = 0; b < 6; b++) begin
        if (dut_pulse[b]) begin
          pc[b]++;
          if (pf[b] < 0) pf[b] = k;
          pl[b] = k;
        end
        if (btn_level[b] && lf[b] < 0) lf[b] = k;
        if (m_out[b] && mf[b] < 0) mf[b] = k;
      end
    end
  endtask

  task automatic do_reset();
    raw = '0;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  int hold [6];

  initial begin
    #3;
    chk("reset_pulses", int'(dut_pulse), 0);
    chk("reset_level", int'(btn_level), 0);
    do_reset();

    // Clean R press held 20 clocks.
    run_scen(1, 30);
    chk("s1_r_count", pc[3], 1);
    chk("s1_r_edge", pf[3], 7);
    chk("s1_model_r_edge", mf[3], 7);
    chk("s1_level_edge", lf[3], 6);
    chk("s1_others", pc[0] + pc[1] + pc[2] + pc[4] + pc[5], 0);
    do_reset();

    // Bouncy C press.
    run_scen(2, 20);
    chk("s2_c_count", pc[4], 1);
    chk("s2_c_edge", pf[4], 10);
    chk("s2_model_c_edge", mf[4], 10);
    do_reset();

    // L and U together.
    run_scen(3, 20);
    chk("s3_l_count", pc[2], 1);
    chk("s3_l_edge", pf[2], 7);
    chk("s3_u_count", pc[1], 1);
    chk("s3_u_edge", pf[1], 8);
    chk("s3_model_u_edge", mf[1], 8);
    do_reset();

    // Release glitch, then a fresh press.
    run_scen(4, 60);
    chk("s4_r_count", pc[3], 2);
    chk("s4_r_first", pf[3], 7);
    chk("s4_r_second", pl[3], 40);
    do_reset();

    // Reset arriving mid-press.
    run_scen(5, 5);
    chk("s5_no_d_before_reset", pc[0], 0);
    #3 Reset = 1'b1;
    #1;
    chk("s5_pulses_in_reset", int'(dut_pulse), 0);
    chk("s5_level_in_reset", int'(btn_level), 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    run_scen(5, 15);
    chk("s5_d_count", pc[0], 1);
    chk("s5_d_edge", pf[0], 7);
    do_reset();

    // Check and C together.
    run_scen(6, 20);
    chk("s6_chk_edge", pf[5], 7);
    chk("s6_c_edge", pf[4], 8);
    chk("s6_counts", pc[5] + pc[4], 2);
    do_reset();

    // Randomized presses, bounces and glitches; one async reset mid-run.
    for (int b = 0; b < 6; b++) hold[b] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int b = 0; b < 6; b++) begin
        if (hold[b] == 0) begin
          raw[b] = 1'($urandom_range(0, 1));
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                               : $urandom_range(4, 20);
        end
        hold[b]--;
      end
      if (cyc == 2000) begin
        #2 Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
      end
      @(posedge Clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
